// File: rtl/writeback_regfile.sv
// Writeback stage and 32x32 architectural register file.
// Selects the writeback value (memory data, ALU result or link address) and
// commits it. Two combinational read ports serve decode. Each port forwards a
// same-cycle write, so a WB->ID hazard needs no stall. A retired-write counter
// is kept for verification.
module writeback_regfile #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jumpI,
    input  logic             memtoRegI,
    input  logic             regWriteI,
    input  logic [WIDTH-1:0] readDataI,
    input  logic [WIDTH-1:0] aluResultI,
    input  logic [4:0]       writeRegistrerI,
    input  logic [WIDTH-1:0] linkAddrI,
    input  logic [4:0]       readReg1I,
    input  logic [4:0]       readReg2I,
    output logic [WIDTH-1:0] readData1O,
    output logic [WIDTH-1:0] readData2O,
    output logic [WIDTH-1:0] wbDataO,
    output logic [4:0]       wbRegO,
    output logic             wbValidO,
    output logic [31:0]      retireCountO
);

    localparam logic [4:0] LINK_REG = 5'd31;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] wb_data;
    logic [4:0]       wb_reg;
    logic             wb_valid;
    logic [31:0]      retire_count_reg;

    // Writeback select: a link write takes priority and always targets $ra.
    always_comb begin
        wb_data = aluResultI;
        wb_reg  = writeRegistrerI;
        if (jumpI && regWriteI) begin
            wb_data = linkAddrI;
            wb_reg  = LINK_REG;
        end else if (memtoRegI) begin
            wb_data = readDataI;
        end
    end

    // Writes to $0 are dropped here, so they neither update the array nor count.
    assign wb_valid = regWriteI && (wb_reg != 5'd0);

    // Register array commit. Entry 0 is never written and stays at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid) begin
            regs[wb_reg] <= wb_data;
        end
    end

    // Retired-write counter. It wraps silently at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_count_reg <= 32'd0;
        end else if (wb_valid) begin
            retire_count_reg <= retire_count_reg + 32'd1;
        end
    end

    // One read port: $0 reads zero, then same-cycle bypass, then the array.
    function automatic logic [WIDTH-1:0] read_port(input logic [4:0] addr);
        logic [WIDTH-1:0] result;
        if (addr == 5'd0) begin
            result = '0;
        end else if (wb_valid && (addr == wb_reg)) begin
            result = wb_data;
        end else begin
            result = regs[addr];
        end
        return result;
    endfunction

    assign readData1O   = read_port(readReg1I);
    assign readData2O   = read_port(readReg2I);
    assign wbDataO      = wb_data;
    assign wbRegO       = wb_reg;
    assign wbValidO     = wb_valid;
    assign retireCountO = retire_count_reg;

endmodule

// File: tb/tb_writeback_regfile.sv
// Testbench for writeback_regfile. Directed scenarios are followed by a
// randomized run. Results are checked against an array-based model of the
// architectural register state.
module tb_writeback_regfile;

    logic        clk;
    logic        rst;
    logic        jumpI;
    logic        memtoRegI;
    logic        regWriteI;
    logic [31:0] readDataI;
    logic [31:0] aluResultI;
    logic [4:0]  writeRegistrerI;
    logic [31:0] linkAddrI;
    logic [4:0]  readReg1I;
    logic [4:0]  readReg2I;
    logic [31:0] readData1O;
    logic [31:0] readData2O;
    logic [31:0] wbDataO;
    logic [4:0]  wbRegO;
    logic        wbValidO;
    logic [31:0] retireCountO;

    int total = 0;
    int bad   = 0;

    // Model of the architectural state.
    logic [31:0] mdl_regs [32];
    logic [31:0] mdl_count;

    writeback_regfile #(.DEPTH(32), .WIDTH(32)) dut (
        .clk(clk), .rst(rst), .jumpI(jumpI), .memtoRegI(memtoRegI),
        .regWriteI(regWriteI), .readDataI(readDataI), .aluResultI(aluResultI),
        .writeRegistrerI(writeRegistrerI), .linkAddrI(linkAddrI),
        .readReg1I(readReg1I), .readReg2I(readReg2I),
        .readData1O(readData1O), .readData2O(readData2O),
        .wbDataO(wbDataO), .wbRegO(wbRegO), .wbValidO(wbValidO),
        .retireCountO(retireCountO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // What the current inputs are meant to write, worked out from the
    // writeback rules.
    task automatic model_wb(output logic [31:0] d, output logic [4:0] r, output logic v);
        if (jumpI && regWriteI) begin
            d = linkAddrI;
            r = 5'd31;
        end else begin
            d = memtoRegI ? readDataI : aluResultI;
            r = writeRegistrerI;
        end
        v = regWriteI && (r != 5'd0);
    endtask

    // Value that a read port should show for an address under the current inputs.
    task automatic model_read(input logic [4:0] a, output logic [31:0] q);
        logic [31:0] d;
        logic [4:0]  r;
        logic        v;
        model_wb(d, r, v);
        if (a == 5'd0)              q = 32'd0;
        else if (v && a == r)       q = d;
        else                        q = mdl_regs[a];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
        mdl_count = 32'd0;
    endtask

    task automatic drive(input logic j, input logic m, input logic w,
                         input logic [31:0] rd, input logic [31:0] alu,
                         input logic [4:0] wr, input logic [31:0] link,
                         input logic [4:0] r1, input logic [4:0] r2);
        jumpI = j; memtoRegI = m; regWriteI = w; readDataI = rd;
        aluResultI = alu; writeRegistrerI = wr; linkAddrI = link;
        readReg1I = r1; readReg2I = r2;
    endtask

    // Apply one clock edge and update the model. Commits only happen while
    // reset is low.
    task automatic edge_commit();
        logic [31:0] d;
        logic [4:0]  r;
        logic        v;
        model_wb(d, r, v);
        @(posedge clk);
        if (!rst && v) begin
            mdl_regs[r] = d;
            mdl_count   = mdl_count + 32'd1;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] q;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 5, 5);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (retireCountO !== 32'd0 || readData1O !== 32'd0) begin
            bad++; $display("FAIL reset_init: count=%h rd1=%h, required 0/0", retireCountO, readData1O);
        end
        // Load r5 = 0x1234, then assert reset in the middle of the cycle.
        drive(0, 0, 1, 0, 32'h1234, 5, 0, 5, 5);
        edge_commit();
        drive(0, 0, 0, 0, 0, 0, 0, 5, 5);
        #1;
        total++;
        if (readData1O !== 32'h1234) begin
            bad++; $display("FAIL reset_load: rd1=%h, required 00001234", readData1O);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (readData1O !== 32'd0 || readData2O !== 32'd0 || retireCountO !== 32'd0) begin
            bad++; $display("FAIL reset_async: rd1=%h rd2=%h count=%h, required all 0",
                            readData1O, readData2O, retireCountO);
        end
        model_clear();
        // While reset is held, a valid write must not commit.
        drive(0, 0, 1, 0, 32'hDEAD_BEEF, 6, 0, 6, 6);
        #1;
        total++;
        if (wbValidO !== 1'b1) begin
            bad++; $display("FAIL reset_valid: wbValid=%b, required 1", wbValidO);
        end
        edge_commit();
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 6, 6);
        #1;
        model_read(5'd6, q);
        total++;
        if (readData1O !== q || retireCountO !== mdl_count) begin
            bad++; $display("FAIL reset_hold: r6=%h count=%h, required %h/%h",
                            readData1O, retireCountO, q, mdl_count);
        end
        $display("reset: r6=%h count=%0d", readData1O, retireCountO);
    endtask

    task automatic test_select();
        drive(0, 0, 1, 32'h5555_000F, 32'hAAAA_0001, 8, 0, 8, 9);
        edge_commit();
        drive(0, 1, 1, 32'h5555_000F, 32'hAAAA_0001, 9, 0, 8, 9);
        #1;
        total++;
        if (wbDataO !== 32'h5555_000F || wbRegO !== 5'd9) begin
            bad++; $display("FAIL select_mem_wb: data=%h reg=%0d, required 5555000f/9", wbDataO, wbRegO);
        end
        edge_commit();
        drive(0, 0, 0, 0, 0, 0, 0, 8, 9);
        #1;
        total++;
        if (readData1O !== 32'hAAAA_0001 || readData2O !== 32'h5555_000F || retireCountO !== 32'd2) begin
            bad++; $display("FAIL select: r8=%h r9=%h count=%0d, required aaaa0001/5555000f/2",
                            readData1O, readData2O, retireCountO);
        end
        $display("select: r8=%h r9=%h count=%0d", readData1O, readData2O, retireCountO);
    endtask

    task automatic test_link();
        logic [31:0] cnt;
        drive(1, 0, 1, 32'h1, 32'h2, 4, 32'h0040_0010, 31, 4);
        #1;
        total++;
        if (wbRegO !== 5'd31 || wbDataO !== 32'h0040_0010 || wbValidO !== 1'b1) begin
            bad++; $display("FAIL link_wb: reg=%0d data=%h valid=%b, required 31/00400010/1",
                            wbRegO, wbDataO, wbValidO);
        end
        edge_commit();
        drive(0, 0, 0, 0, 0, 0, 0, 31, 4);
        #1;
        total++;
        if (readData1O !== 32'h0040_0010 || readData2O !== 32'd0) begin
            bad++; $display("FAIL link: r31=%h r4=%h, required 00400010/00000000", readData1O, readData2O);
        end
        cnt = retireCountO;
        drive(1, 0, 0, 32'h1, 32'h2, 4, 32'h0040_0020, 31, 4);
        #1;
        total++;
        if (wbValidO !== 1'b0) begin
            bad++; $display("FAIL link_nowrite_valid: valid=%b, required 0", wbValidO);
        end
        edge_commit();
        drive(0, 0, 0, 0, 0, 0, 0, 31, 4);
        #1;
        total++;
        if (readData1O !== 32'h0040_0010 || readData2O !== 32'd0 || retireCountO !== cnt) begin
            bad++; $display("FAIL link_nowrite: r31=%h r4=%h count=%0d, required 00400010/0/%0d",
                            readData1O, readData2O, retireCountO, cnt);
        end
        $display("link: r31=%h count=%0d", readData1O, retireCountO);
    endtask

    task automatic test_zero();
        logic [31:0] cnt;
        cnt = retireCountO;
        drive(0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        #1;
        total++;
        if (wbValidO !== 1'b0 || readData1O !== 32'd0 || readData2O !== 32'd0) begin
            bad++; $display("FAIL zero_pre: valid=%b rd1=%h rd2=%h, required 0/0/0",
                            wbValidO, readData1O, readData2O);
        end
        edge_commit();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (readData1O !== 32'd0 || readData2O !== 32'd0 || retireCountO !== cnt) begin
            bad++; $display("FAIL zero_post: rd1=%h rd2=%h count=%0d, required 0/0/%0d",
                            readData1O, readData2O, retireCountO, cnt);
        end
        $display("zero: rd1=%h count=%0d", readData1O, retireCountO);
    endtask

    task automatic test_bypass();
        drive(0, 0, 1, 0, 32'h11, 3, 0, 3, 3);
        edge_commit();
        drive(0, 0, 1, 0, 32'h22, 3, 0, 3, 3);
        #1;
        total++;
        if (readData1O !== 32'h22 || readData2O !== 32'h22) begin
            bad++; $display("FAIL bypass_pre: rd1=%h rd2=%h, required 22/22", readData1O, readData2O);
        end
        edge_commit();
        drive(0, 0, 0, 0, 0, 0, 0, 3, 3);
        #1;
        total++;
        if (readData1O !== 32'h22 || readData2O !== 32'h22) begin
            bad++; $display("FAIL bypass_post: rd1=%h rd2=%h, required 22/22", readData1O, readData2O);
        end
        $display("bypass: r3=%h", readData1O);
    endtask

    task automatic test_back_to_back();
        logic [31:0] cnt;
        cnt = retireCountO;
        drive(0, 0, 1, 0, 32'h0000_0A0A, 7, 0, 7, 1);
        edge_commit();
        drive(0, 1, 1, 32'h0000_0B0B, 0, 7, 0, 7, 1);
        edge_commit();
        drive(0, 0, 0, 0, 0, 0, 0, 7, 1);
        #1;
        total++;
        if (readData1O !== 32'h0000_0B0B || retireCountO !== cnt + 32'd2) begin
            bad++; $display("FAIL back_to_back: r7=%h count=%0d, required 00000b0b/%0d",
                            readData1O, retireCountO, cnt + 32'd2);
        end
        $display("back_to_back: r7=%h count=%0d", readData1O, retireCountO);
    endtask

    task automatic test_random();
        logic [31:0] ed, q1, q2;
        logic [4:0]  er;
        logic        ev;
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 4) == 0), $urandom_range(0, 1), ($urandom_range(0, 9) < 7),
                  $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) readReg1I = writeRegistrerI;
            if ($urandom_range(0, 3) == 0) readReg2I = (jumpI ? 5'd31 : writeRegistrerI);
            #1;
            model_wb(ed, er, ev);
            model_read(readReg1I, q1);
            model_read(readReg2I, q2);
            total++;
            if (wbDataO !== ed || wbRegO !== er || wbValidO !== ev) begin
                bad++; $display("FAIL rand_wb[%0d]: data=%h reg=%0d valid=%b, required %h/%0d/%b",
                                n, wbDataO, wbRegO, wbValidO, ed, er, ev);
            end
            total++;
            if (readData1O !== q1 || readData2O !== q2) begin
                bad++; $display("FAIL rand_read[%0d]: rd1=%h rd2=%h, required %h/%h",
                                n, readData1O, readData2O, q1, q2);
            end
            edge_commit();
            total++;
            if (retireCountO !== mdl_count) begin
                bad++; $display("FAIL rand_count[%0d]: count=%0d, required %0d", n, retireCountO, mdl_count);
            end
            $display("rand %0d: reg=%0d data=%h valid=%b count=%0d", n, er, ed, ev, retireCountO);
        end
        // Sweep every register against the model.
        for (int a = 0; a < 32; a++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
            #1;
            model_read(5'(a), q1);
            model_read(5'(31 - a), q2);
            total++;
            if (readData1O !== q1 || readData2O !== q2) begin
                bad++; $display("FAIL sweep[%0d]: rd1=%h rd2=%h, required %h/%h",
                                a, readData1O, readData2O, q1, q2);
            end
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        force dut.retire_count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.retire_count_reg;
        #1;
        if (retireCountO === 32'hFFFF_FFFF) begin
            drive(0, 0, 1, 0, 32'h77, 12, 0, 12, 12);
            edge_commit();
            drive(0, 0, 0, 0, 0, 0, 0, 12, 12);
            #1;
            total++;
            if (retireCountO !== 32'd0 || readData1O !== 32'h77) begin
                bad++; $display("FAIL wrap: count=%h r12=%h, required 00000000/00000077",
                                retireCountO, readData1O);
            end
            $display("wrap: count=%h", retireCountO);
        end else begin
            $display("wrap: counter preload not retained by simulator, wrap check skipped");
        end
    endtask

    initial begin
        test_reset();
        test_select();
        test_link();
        test_zero();
        test_bypass();
        test_back_to_back();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
